sparc_ffu_frf_ecc: RTL

Downstream of the floating-point register file read port: takes the registered 78-bit read word (two 39-bit halves, each 32 data + 7 check bits) and performs SEC-DED checking and correction per half. Delivers corrected 64-bit data to the FFU datapath one cycle later. Raises correctable and uncorrectable error flags and captures the first error in a log. Runs a single-entry scrub engine that requests a write-back of the corrected word into the register file through a req/gnt handshake.

---
 rtl/sparc_ffu_frf_ecc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sparc_ffu_frf_ecc.sv
// SEC-DED check/correct stage for the FRF read port: two 39-bit halves per
// word. It also runs a single-entry scrub write-back engine and a first-error log.
module sparc_ffu_frf_ecc #(
    parameter int CNT_W = 8
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic             rd_vld,
    input  logic [6:0]       rd_addr,
    input  logic [77:0]      frf_dp_data,
    input  logic             scrub_en,
    input  logic             scrub_gnt,
    input  logic             log_clr,
    output logic             ecc_vld,
    output logic [63:0]      ecc_dp_data,
    output logic [1:0]       ecc_ce,
    output logic [1:0]       ecc_ue,
    output logic             scrub_req,
    output logic [6:0]       scrub_addr,
    output logic [77:0]      scrub_data,
    output logic [CNT_W-1:0] scrub_drop_cnt,
    output logic             log_vld,
    output logic [6:0]       log_addr,
    output logic             log_ue,
    output logic [13:0]      log_syn
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    // Hamming position of data bit idx: the idx-th non-power-of-two in 3..38.
    function automatic logic [5:0] data_pos(input int idx);
        int n;
        logic [5:0] r;
        n = 0;
        r = '0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) r = 6'(p);
                n++;
            end
        end
        return r;
    endfunction

    logic [1:0]  ce_c;
    logic [1:0]  ue_c;
    logic [63:0] cor_data;
    logic [77:0] cor_cw;
    logic [13:0] syn_c;

    for (genvar h = 0; h < 2; h++) begin : g_half
        logic [38:0] cw;
        logic [5:0]  rc;
        logic [5:0]  nc;
        logic [5:0]  s;
        logic [5:0]  pos;
        logic [31:0] cd;
        logic        par;
        logic        ce;
        logic        ue;

        assign cw = frf_dp_data[39*h +: 39];

        // Syndrome, classification, data correction and check-bit regeneration.
        always_comb begin
            rc  = '0;
            nc  = '0;
            pos = '0;
            cd  = cw[31:0];
            ce  = 1'b0;
            ue  = 1'b0;
            for (int i = 0; i < 32; i++) begin
                pos = data_pos(i);
                for (int k = 0; k < 6; k++) rc[k] = rc[k] ^ (pos[k] & cw[i]);
            end
            s   = rc ^ cw[37:32];
            par = ^cw;
            if (par) begin
                if (s > 6'd38) begin
                    ue = 1'b1;
                end else begin
                    ce = 1'b1;
                    // Zero or power-of-two syndromes match no data position.
                    for (int i = 0; i < 32; i++)
                        if (s == data_pos(i)) cd[i] = ~cd[i];
                end
            end else if (s != '0) begin
                ue = 1'b1;
            end
            for (int i = 0; i < 32; i++) begin
                pos = data_pos(i);
                for (int k = 0; k < 6; k++) nc[k] = nc[k] ^ (pos[k] & cd[i]);
            end
        end

        assign ce_c[h]             = ce;
        assign ue_c[h]             = ue;
        assign cor_data[32*h +: 32] = cd;
        assign cor_cw[39*h +: 39]   = {(^cd) ^ (^nc), nc, cd};
        assign syn_c[7*h +: 7]      = {par, s};
    end

    logic elig;
    logic err;
    logic err_ue;

    assign elig   = rd_vld & (|ce_c) & ~(|ue_c) & scrub_en;
    assign err    = rd_vld & ((|ce_c) | (|ue_c));
    assign err_ue = rd_vld & (|ue_c);

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ecc_vld     <= 1'b0;
            ecc_dp_data <= '0;
            ecc_ce      <= '0;
            ecc_ue      <= '0;
        end else begin
            ecc_vld <= rd_vld;
            ecc_ce  <= rd_vld ? ce_c : 2'b00;
            ecc_ue  <= rd_vld ? ue_c : 2'b00;
            if (rd_vld) ecc_dp_data <= cor_data;
        end
    end

    state_t state;
    state_t next_state;
    logic   load;
    logic   drop_inc;

    always_comb begin
        next_state = state;
        load       = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (elig) begin
                    load       = 1'b1;
                    next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (scrub_gnt) begin
                    load       = elig;
                    next_state = elig ? S_REQ : S_IDLE;
                end else begin
                    drop_inc = elig;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state          <= S_IDLE;
            scrub_addr     <= '0;
            scrub_data     <= '0;
            scrub_drop_cnt <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                scrub_addr <= rd_addr;
                scrub_data <= cor_cw;
            end
            if (drop_inc && scrub_drop_cnt != {CNT_W{1'b1}})
                scrub_drop_cnt <= scrub_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign scrub_req = (state == S_REQ);

    // A clear on the same edge as an error still lets the error be captured.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            log_vld  <= 1'b0;
            log_addr <= '0;
            log_ue   <= 1'b0;
            log_syn  <= '0;
        end else if (err && (!log_vld || log_clr || (err_ue && !log_ue))) begin
            log_vld  <= 1'b1;
            log_addr <= rd_addr;
            log_ue   <= err_ue;
            log_syn  <= syn_c;
        end else if (log_clr) begin
            log_vld  <= 1'b0;
            log_addr <= '0;
            log_ue   <= 1'b0;
            log_syn  <= '0;
        end
    end

endmodule
